// File: rtl/i2c_seq_pkg.sv
// i2c_seq_pkg: register map, command bytes and FSM states shared by the
// I2C register sequencer and its Wishbone access engine.
package i2c_seq_pkg;

   localparam logic [2:0] ADR_PRER_LO = 3'd0;
   localparam logic [2:0] ADR_PRER_HI = 3'd1;
   localparam logic [2:0] ADR_CTR     = 3'd2;
   localparam logic [2:0] ADR_TXR     = 3'd3;
   localparam logic [2:0] ADR_RXR     = 3'd3;
   localparam logic [2:0] ADR_CR      = 3'd4;
   localparam logic [2:0] ADR_SR      = 3'd4;

   localparam logic [7:0] CMD_STA_WR = 8'h91;
   localparam logic [7:0] CMD_WR     = 8'h11;
   localparam logic [7:0] CMD_WR_STO = 8'h51;
   localparam logic [7:0] CMD_RD_STO = 8'h69;
   localparam logic [7:0] CMD_STO    = 8'h41;
   localparam logic [7:0] CTR_EN     = 8'h80;
   localparam logic [7:0] CTR_OFF    = 8'h00;

   localparam int SR_RXACK = 7;
   localparam int SR_BUSY  = 6;
   localparam int SR_TIP   = 1;

   typedef enum logic [3:0] {
      S_INIT,
      S_IDLE,
      S_LOAD_TX,
      S_WR_CR,
      S_GAP,
      S_POLL_TIP,
      S_RD_RX,
      S_ABORT_STO,
      S_STOPWAIT,
      S_RECOVER,
      S_RESP
   } state_t;

   function automatic logic [7:0] step_cmd(input logic [1:0] step,
                                           input logic       rd);
      logic [7:0] c;
      c = CMD_RD_STO;
      case (step)
         2'd0:    c = CMD_STA_WR;
         2'd1:    c = CMD_WR;
         2'd2:    c = rd ? CMD_STA_WR : CMD_WR_STO;
         default: c = CMD_RD_STO;
      endcase
      return c;
   endfunction

   function automatic logic [7:0] step_txr(input logic [1:0] step,
                                           input logic       rd,
                                           input logic [6:0] dev,
                                           input logic [7:0] rg,
                                           input logic [7:0] wdata);
      logic [7:0] t;
      t = 8'h00;
      case (step)
         2'd0:    t = {dev, 1'b0};
         2'd1:    t = rg;
         2'd2:    t = rd ? {dev, 1'b1} : wdata;
         default: t = 8'h00;
      endcase
      return t;
   endfunction

endpackage

// File: rtl/i2c_wb_access.sv
// i2c_wb_access: one Wishbone access at a time; holds cyc/stb until ack
// and leaves the bus idle for at least one cycle before the next access.
module i2c_wb_access (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [2:0] adr,
   input  logic [7:0] dat,
   input  logic       we,
   output logic       done,
   output logic [7:0] rdata,
   output logic       cyc,
   output logic       stb,
   output logic       bus_we,
   output logic [2:0] bus_adr,
   output logic [7:0] bus_wdat,
   input  logic [7:0] bus_rdat,
   input  logic       ack
);

   // The caller captures rdata on the same edge that ends the access.
   assign done  = cyc & ack;
   assign rdata = bus_rdat;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cyc      <= 1'b0;
         stb      <= 1'b0;
         bus_we   <= 1'b0;
         bus_adr  <= 3'd0;
         bus_wdat <= 8'h00;
      end else if (cyc) begin
         if (ack) begin
            cyc <= 1'b0;
            stb <= 1'b0;
         end
      end else if (start) begin
         cyc      <= 1'b1;
         stb      <= 1'b1;
         bus_we   <= we;
         bus_adr  <= adr;
         bus_wdat <= dat;
      end
   end

endmodule

// File: rtl/i2c_reg_sequencer.sv
// i2c_reg_sequencer: autonomous Wishbone master that runs complete
// single-register I2C writes and reads through an i2c_master_top core.
module i2c_reg_sequencer
   import i2c_seq_pkg::*;
#(
   parameter logic [15:0] PRESCALE = 16'd99,
   parameter logic [15:0] TIMEOUT  = 16'd4095
) (
   input  logic       wb_clk_i,
   input  logic       arst_i,
   input  logic       req_valid_i,
   output logic       req_ready_o,
   input  logic       req_rd_i,
   input  logic [6:0] req_dev_i,
   input  logic [7:0] req_reg_i,
   input  logic [7:0] req_wdata_i,
   output logic       rsp_valid_o,
   output logic [7:0] rsp_rdata_o,
   output logic       rsp_nack_o,
   output logic       rsp_tmo_o,
   output logic       wbm_cyc_o,
   output logic       wbm_stb_o,
   output logic       wbm_we_o,
   output logic [2:0] wbm_adr_o,
   output logic [7:0] wbm_dat_o,
   input  logic [7:0] wbm_dat_i,
   input  logic       wbm_ack_i
);

   state_t      state;
   logic [1:0]  step;
   logic        pend;
   logic        gap;
   logic [15:0] polls;
   logic        rd;
   logic [6:0]  dev;
   logic [7:0]  rg;
   logic [7:0]  wdata;

   logic        has_acc;
   logic        acc_start;
   logic        acc_done;
   logic        acc_we;
   logic [2:0]  acc_adr;
   logic [7:0]  acc_dat;
   logic [7:0]  acc_rdata;
   logic        expired;

   assign has_acc   = !(state inside {S_IDLE, S_GAP, S_RESP});
   assign acc_start = has_acc && !pend;
   assign expired   = (polls == TIMEOUT);

   always_comb begin
      acc_we  = 1'b1;
      acc_adr = ADR_CR;
      acc_dat = 8'h00;
      unique case (state)
         S_INIT: begin
            unique case (step)
               2'd0: begin
                  acc_adr = ADR_PRER_LO;
                  acc_dat = PRESCALE[7:0];
               end
               2'd1: begin
                  acc_adr = ADR_PRER_HI;
                  acc_dat = PRESCALE[15:8];
               end
               default: begin
                  acc_adr = ADR_CTR;
                  acc_dat = CTR_EN;
               end
            endcase
         end
         S_LOAD_TX: begin
            acc_adr = ADR_TXR;
            acc_dat = step_txr(step, rd, dev, rg, wdata);
         end
         S_WR_CR:     acc_dat = step_cmd(step, rd);
         S_ABORT_STO: acc_dat = CMD_STO;
         S_POLL_TIP, S_STOPWAIT: begin
            acc_we  = 1'b0;
            acc_adr = ADR_SR;
         end
         S_RD_RX: begin
            acc_we  = 1'b0;
            acc_adr = ADR_RXR;
         end
         S_RECOVER: begin
            acc_adr = ADR_CTR;
            acc_dat = step[0] ? CTR_EN : CTR_OFF;
         end
         default: ;
      endcase
   end

   i2c_wb_access u_acc (
      .clk      (wb_clk_i),
      .rst_n    (arst_i),
      .start    (acc_start),
      .adr      (acc_adr),
      .dat      (acc_dat),
      .we       (acc_we),
      .done     (acc_done),
      .rdata    (acc_rdata),
      .cyc      (wbm_cyc_o),
      .stb      (wbm_stb_o),
      .bus_we   (wbm_we_o),
      .bus_adr  (wbm_adr_o),
      .bus_wdat (wbm_dat_o),
      .bus_rdat (wbm_dat_i),
      .ack      (wbm_ack_i)
   );

   always_ff @(posedge wb_clk_i or negedge arst_i) begin
      if (!arst_i) begin
         state       <= S_INIT;
         step        <= 2'd0;
         pend        <= 1'b0;
         gap         <= 1'b0;
         polls       <= 16'd0;
         rd          <= 1'b0;
         dev         <= 7'd0;
         rg          <= 8'h00;
         wdata       <= 8'h00;
         req_ready_o <= 1'b0;
         rsp_valid_o <= 1'b0;
         rsp_rdata_o <= 8'h00;
         rsp_nack_o  <= 1'b0;
         rsp_tmo_o   <= 1'b0;
      end else begin
         if (acc_start) pend <= 1'b1;
         if (acc_done)  pend <= 1'b0;
         unique case (state)
            S_INIT: if (acc_done) begin
               if (step == 2'd2) begin
                  step        <= 2'd0;
                  req_ready_o <= 1'b1;
                  state       <= S_IDLE;
               end else begin
                  step <= step + 2'd1;
               end
            end
            S_IDLE: if (req_valid_i && req_ready_o) begin
               rd          <= req_rd_i;
               dev         <= req_dev_i;
               rg          <= req_reg_i;
               wdata       <= req_wdata_i;
               req_ready_o <= 1'b0;
               rsp_nack_o  <= 1'b0;
               rsp_tmo_o   <= 1'b0;
               step        <= 2'd0;
               state       <= S_LOAD_TX;
            end
            S_LOAD_TX: if (acc_done) state <= S_WR_CR;
            S_WR_CR: if (acc_done) begin
               gap   <= 1'b0;
               state <= S_GAP;
            end
            S_GAP: begin
               gap <= 1'b1;
               if (gap) begin
                  polls <= 16'd0;
                  state <= S_POLL_TIP;
               end
            end
            S_POLL_TIP: if (acc_done) begin
               if (acc_rdata[SR_TIP]) begin
                  if (expired) begin
                     step  <= 2'd0;
                     state <= S_RECOVER;
                  end else begin
                     polls <= polls + 16'd1;
                  end
               end else if (step == 2'd3) begin
                  state <= S_RD_RX;
               end else if (step == 2'd2 && !rd) begin
                  rsp_nack_o  <= acc_rdata[SR_RXACK];
                  rsp_valid_o <= 1'b1;
                  state       <= S_RESP;
               end else if (acc_rdata[SR_RXACK]) begin
                  rsp_nack_o <= 1'b1;
                  state      <= S_ABORT_STO;
               end else begin
                  step  <= step + 2'd1;
                  state <= (step == 2'd2) ? S_WR_CR : S_LOAD_TX;
               end
            end
            S_RD_RX: if (acc_done) begin
               rsp_rdata_o <= acc_rdata;
               rsp_valid_o <= 1'b1;
               state       <= S_RESP;
            end
            S_ABORT_STO: if (acc_done) begin
               polls <= 16'd0;
               state <= S_STOPWAIT;
            end
            S_STOPWAIT: if (acc_done) begin
               if (acc_rdata[SR_BUSY]) begin
                  if (expired) begin
                     step  <= 2'd0;
                     state <= S_RECOVER;
                  end else begin
                     polls <= polls + 16'd1;
                  end
               end else begin
                  rsp_valid_o <= 1'b1;
                  state       <= S_RESP;
               end
            end
            // Disable then re-enable the core to drop a stuck transfer.
            S_RECOVER: if (acc_done) begin
               if (step[0]) begin
                  rsp_nack_o  <= 1'b0;
                  rsp_tmo_o   <= 1'b1;
                  rsp_valid_o <= 1'b1;
                  state       <= S_RESP;
               end else begin
                  step <= 2'd1;
               end
            end
            S_RESP: begin
               rsp_valid_o <= 1'b0;
               req_ready_o <= 1'b1;
               state       <= S_IDLE;
            end
            default: state <= S_INIT;
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// tb_i2c_reg_sequencer: directed bench with a behavioural i2c_master_top
// register model and an I2C slave at address 0x50.
module tb_i2c_reg_sequencer;

   localparam logic [6:0] SLAVE      = 7'h50;
   localparam logic [7:0] SLAVE_DATA = 8'h3C;

   logic       clk = 1'b0;
   logic       arst_i = 1'b0;
   logic       req_valid_i = 1'b0;
   logic       req_ready_o;
   logic       req_rd_i = 1'b0;
   logic [6:0] req_dev_i = 7'd0;
   logic [7:0] req_reg_i = 8'h00;
   logic [7:0] req_wdata_i = 8'h00;
   logic       rsp_valid_o;
   logic [7:0] rsp_rdata_o;
   logic       rsp_nack_o;
   logic       rsp_tmo_o;
   logic       wbm_cyc_o;
   logic       wbm_stb_o;
   logic       wbm_we_o;
   logic [2:0] wbm_adr_o;
   logic [7:0] wbm_dat_o;
   logic [7:0] wbm_dat_i;
   logic       wbm_ack_i;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   i2c_reg_sequencer #(.PRESCALE(16'h0063), .TIMEOUT(16'd16)) dut (
      .wb_clk_i    (clk),
      .arst_i      (arst_i),
      .req_valid_i (req_valid_i),
      .req_ready_o (req_ready_o),
      .req_rd_i    (req_rd_i),
      .req_dev_i   (req_dev_i),
      .req_reg_i   (req_reg_i),
      .req_wdata_i (req_wdata_i),
      .rsp_valid_o (rsp_valid_o),
      .rsp_rdata_o (rsp_rdata_o),
      .rsp_nack_o  (rsp_nack_o),
      .rsp_tmo_o   (rsp_tmo_o),
      .wbm_cyc_o   (wbm_cyc_o),
      .wbm_stb_o   (wbm_stb_o),
      .wbm_we_o    (wbm_we_o),
      .wbm_adr_o   (wbm_adr_o),
      .wbm_dat_o   (wbm_dat_o),
      .wbm_dat_i   (wbm_dat_i),
      .wbm_ack_i   (wbm_ack_i)
   );

   // ---------------- core register model ----------------
   int          lat = 0;
   logic        scl_hold = 1'b0;
   int          acnt;
   int          tipc;
   logic        tip, busy, rxack, sto_pend;
   logic [7:0]  txr, rxr;
   logic [10:0] wlog[$];
   int          polls = 0;

   assign wbm_ack_i = wbm_cyc_o && wbm_stb_o && (acnt >= lat);
   assign wbm_dat_i = (wbm_adr_o == 3'd3) ? rxr :
                      (wbm_adr_o == 3'd4) ? {rxack, busy, 4'b0, tip, 1'b0} :
                      8'h00;

   always @(posedge clk or negedge arst_i) begin
      if (!arst_i) begin
         acnt <= 0; tipc <= 0; tip <= 1'b0; busy <= 1'b0;
         rxack <= 1'b0; sto_pend <= 1'b0; txr <= 8'h00; rxr <= 8'h00;
      end else begin
         if (wbm_cyc_o && wbm_stb_o && !wbm_ack_i) acnt <= acnt + 1;
         else acnt <= 0;
         if (tip && !scl_hold) begin
            tipc <= tipc - 1;
            if (tipc <= 1) begin
               tip <= 1'b0;
               if (sto_pend) busy <= 1'b0;
            end
         end
         if (wbm_ack_i && wbm_we_o) begin
            wlog.push_back({wbm_adr_o, wbm_dat_o});
            if (wbm_adr_o == 3'd2 && !wbm_dat_o[7]) begin
               tip <= 1'b0;
               busy <= 1'b0;
            end
            if (wbm_adr_o == 3'd3) txr <= wbm_dat_o;
            if (wbm_adr_o == 3'd4) begin
               tip <= 1'b1;
               tipc <= 6;
               sto_pend <= wbm_dat_o[6];
               if (wbm_dat_o[7]) busy <= 1'b1;
               if (wbm_dat_o[4])
                  rxack <= wbm_dat_o[7] ? (txr[7:1] != SLAVE) : 1'b0;
               if (wbm_dat_o[5]) rxr <= SLAVE_DATA;
            end
         end
         if (wbm_ack_i && !wbm_we_o && wbm_adr_o == 3'd4) polls <= polls + 1;
      end
   end

   // ---------------- bus protocol monitor ----------------
   logic ack_q = 1'b0;
   int   ncnt = 0;
   int   t_cr = 0;
   int   last_gap = -1;
   bit   armed = 1'b0;
   int   proto_err = 0;

   always @(posedge clk) ack_q <= wbm_ack_i;

   always @(negedge clk) begin
      ncnt++;
      if (arst_i) begin
         if (ack_q && wbm_cyc_o) proto_err++;
         if (wbm_stb_o !== wbm_cyc_o) proto_err++;
         if (wbm_ack_i && wbm_we_o && wbm_adr_o == 3'd4) begin
            t_cr = ncnt;
            armed = 1'b1;
         end else if (armed && wbm_cyc_o && !wbm_we_o && wbm_adr_o == 3'd4) begin
            last_gap = ncnt - t_cr;
            armed = 1'b0;
         end
      end else begin
         armed = 1'b0;
      end
   end

   // Index of first difference of the write log from base, -1 if equal,
   // -2 on a length difference.
   function automatic int seq_diff(input int base, input logic [10:0] exp[$]);
      if (wlog.size() != base + exp.size()) return -2;
      foreach (exp[i]) if (wlog[base + i] !== exp[i]) return i;
      return -1;
   endfunction

   task automatic run_req(input logic rd, input logic [6:0] dev,
                          input logic [7:0] rg, input logic [7:0] wd,
                          output logic got, output logic rdy_after,
                          output logic nk, output logic tm);
      int n;
      n = 0;
      while (!req_ready_o && n < 500) begin
         @(negedge clk);
         n++;
      end
      req_rd_i = rd;
      req_dev_i = dev;
      req_reg_i = rg;
      req_wdata_i = wd;
      req_valid_i = 1'b1;
      @(negedge clk);
      req_valid_i = 1'b0;
      rdy_after = req_ready_o;
      got = 1'b0;
      n = 0;
      while (!got && n < 3000) begin
         if (rsp_valid_o) got = 1'b1;
         else begin
            @(negedge clk);
            n++;
         end
      end
      nk = rsp_nack_o;
      tm = rsp_tmo_o;
   endtask

   task automatic test_reset();
      int n, base, d;
      logic [25:0] outs;
      arst_i = 1'b0;
      repeat (3) @(negedge clk);
      outs = {req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_nack_o, rsp_tmo_o,
              wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o};
      n_chk++;
      if (outs !== 26'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %h need 0", outs);
      end
      base = wlog.size();
      arst_i = 1'b1;
      n = 0;
      while (!req_ready_o && n < 100) begin
         @(negedge clk);
         n++;
      end
      n_chk++;
      if (req_ready_o !== 1'b1) begin
         n_fail++;
         $display("FAIL init_ready: got %b need 1", req_ready_o);
      end
      d = seq_diff(base, '{11'h063, 11'h100, 11'h280});
      n_chk++;
      if (d != -1) begin
         n_fail++;
         $display("FAIL init_seq: diff %0d, %0d writes, need 3", d, wlog.size() - base);
      end
   endtask

   task automatic test_write(input string tag);
      int base, d;
      logic got, rdy, nk, tm;
      base = wlog.size();
      run_req(1'b0, 7'h50, 8'h12, 8'hA5, got, rdy, nk, tm);
      n_chk++;
      if (got !== 1'b1) begin
         n_fail++;
         $display("FAIL %s_rsp: no response, got %b need 1", tag, got);
      end
      n_chk++;
      if (rdy !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_ready_drop: got %b need 0", tag, rdy);
      end
      n_chk++;
      if ({nk, tm} !== 2'b00) begin
         n_fail++;
         $display("FAIL %s_status: nack/tmo %b need 00", tag, {nk, tm});
      end
      d = seq_diff(base, '{11'h3A0, 11'h491, 11'h312, 11'h411, 11'h3A5, 11'h451});
      n_chk++;
      if (d != -1) begin
         n_fail++;
         $display("FAIL %s_seq: diff %0d, %0d writes, need 6", tag, d, wlog.size() - base);
      end
      n_chk++;
      if (last_gap != 4) begin
         n_fail++;
         $display("FAIL %s_cr_gap: got %0d need 4", tag, last_gap);
      end
      @(negedge clk);
      n_chk++;
      if ({rsp_valid_o, req_ready_o} !== 2'b01) begin
         n_fail++;
         $display("FAIL %s_after_rsp: valid/ready %b need 01", tag, {rsp_valid_o, req_ready_o});
      end
   endtask

   task automatic test_read(input string tag);
      int base, d;
      logic got, rdy, nk, tm;
      base = wlog.size();
      run_req(1'b1, 7'h50, 8'h12, 8'h00, got, rdy, nk, tm);
      n_chk++;
      if (got !== 1'b1) begin
         n_fail++;
         $display("FAIL %s_rsp: no response, got %b need 1", tag, got);
      end
      n_chk++;
      if (rsp_rdata_o !== 8'h3C) begin
         n_fail++;
         $display("FAIL %s_rdata: got %h need 3c", tag, rsp_rdata_o);
      end
      n_chk++;
      if ({nk, tm} !== 2'b00) begin
         n_fail++;
         $display("FAIL %s_status: nack/tmo %b need 00", tag, {nk, tm});
      end
      d = seq_diff(base, '{11'h3A0, 11'h491, 11'h312, 11'h411, 11'h3A1, 11'h491, 11'h469});
      n_chk++;
      if (d != -1) begin
         n_fail++;
         $display("FAIL %s_seq: diff %0d, %0d writes, need 7", tag, d, wlog.size() - base);
      end
   endtask

   task automatic test_absent();
      int base, d;
      logic got, rdy, nk, tm;
      base = wlog.size();
      run_req(1'b0, 7'h23, 8'h12, 8'h77, got, rdy, nk, tm);
      n_chk++;
      if (got !== 1'b1) begin
         n_fail++;
         $display("FAIL absent_rsp: no response, got %b need 1", got);
      end
      n_chk++;
      if ({nk, tm} !== 2'b10) begin
         n_fail++;
         $display("FAIL absent_status: nack/tmo %b need 10", {nk, tm});
      end
      d = seq_diff(base, '{11'h346, 11'h491, 11'h441});
      n_chk++;
      if (d != -1) begin
         n_fail++;
         $display("FAIL absent_seq: diff %0d, %0d writes, need 3", d, wlog.size() - base);
      end
      n_chk++;
      if (rsp_rdata_o !== 8'h3C) begin
         n_fail++;
         $display("FAIL absent_rdata_hold: got %h need 3c", rsp_rdata_o);
      end
   endtask

   task automatic test_timeout();
      int base, d, p0;
      logic got, rdy, nk, tm;
      base = wlog.size();
      p0 = polls;
      scl_hold = 1'b1;
      run_req(1'b0, 7'h50, 8'h12, 8'hA5, got, rdy, nk, tm);
      scl_hold = 1'b0;
      n_chk++;
      if (got !== 1'b1) begin
         n_fail++;
         $display("FAIL tmo_rsp: no response, got %b need 1", got);
      end
      n_chk++;
      if ({nk, tm} !== 2'b01) begin
         n_fail++;
         $display("FAIL tmo_status: nack/tmo %b need 01", {nk, tm});
      end
      n_chk++;
      if (polls - p0 != 17) begin
         n_fail++;
         $display("FAIL tmo_polls: got %0d need 17", polls - p0);
      end
      d = seq_diff(base, '{11'h3A0, 11'h491, 11'h200, 11'h280});
      n_chk++;
      if (d != -1) begin
         n_fail++;
         $display("FAIL tmo_seq: diff %0d, %0d writes, need 4", d, wlog.size() - base);
      end
   endtask

   task automatic test_reset_mid(input int l);
      int n, p0, base, d;
      logic [25:0] outs;
      lat = l;
      n = 0;
      while (!req_ready_o && n < 500) begin
         @(negedge clk);
         n++;
      end
      p0 = polls;
      req_rd_i = 1'b1;
      req_dev_i = 7'h50;
      req_reg_i = 8'h12;
      req_valid_i = 1'b1;
      @(negedge clk);
      req_valid_i = 1'b0;
      n = 0;
      while (polls == p0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      n_chk++;
      if (polls == p0) begin
         n_fail++;
         $display("FAIL mid%0d_reach_poll: polls %0d need >%0d", l, polls, p0);
      end
      arst_i = 1'b0;
      #1;
      outs = {req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_nack_o, rsp_tmo_o,
              wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o};
      n_chk++;
      if (outs !== 26'd0) begin
         n_fail++;
         $display("FAIL mid%0d_outputs: got %h need 0", l, outs);
      end
      @(negedge clk);
      base = wlog.size();
      arst_i = 1'b1;
      n = 0;
      while (!req_ready_o && n < 200) begin
         @(negedge clk);
         n++;
      end
      d = seq_diff(base, '{11'h063, 11'h100, 11'h280});
      n_chk++;
      if (d != -1 || req_ready_o !== 1'b1) begin
         n_fail++;
         $display("FAIL mid%0d_reinit: diff %0d ready %b need -1/1", l, d, req_ready_o);
      end
      test_read($sformatf("mid%0d_read", l));
   endtask

   initial begin
      test_reset();
      test_write("write");
      test_read("read");
      test_absent();
      test_timeout();
      test_write("write_after_tmo");
      test_reset_mid(0);
      lat = 3;
      test_write("lat3_write");
      test_read("lat3_read");
      test_reset_mid(3);
      n_chk++;
      if (proto_err != 0) begin
         n_fail++;
         $display("FAIL wb_protocol: %0d violations need 0", proto_err);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/i2c_reg_sequencer.md
# i2c_reg_sequencer

Wishbone master that sits directly upstream of `i2c_master_top` and drives its register interface autonomously. It turns a single-request "write/read one 8-bit register of I2C device D" handshake into the full I2C sequence: prescale/enable, START, address, data, repeated START, STOP. It polls the core's status register for completion and returns read data plus ACK/timeout status. It lets control logic without a CPU access I2C peripherals.

## Interface
- `PRESCALE`, 16'd99: value written to PRER after reset (low byte, then high byte).
- `TIMEOUT`, 16'd4095: maximum status polls per wait phase before the transaction aborts.
- `wb_clk_i  in  1`: clock.
- `arst_i  in  1`: reset, asynchronous, active-low.
- `req_valid_i  in  1`: request valid.
- `req_ready_o  out  1`: high only in IDLE after init completes.
- `req_rd_i  in  1`: 1 = register read, 0 = register write.
- `req_dev_i  in  7`: 7-bit I2C device address.
- `req_reg_i  in  8`: register index.
- `req_wdata_i  in  8`: write data.
- `rsp_valid_o  out  1`: one-cycle completion pulse.
- `rsp_rdata_o  out  8`: read data; holds its value until the next read response.
- `rsp_nack_o  out  1`: slave NACKed; valid with `rsp_valid_o`.
- `rsp_tmo_o  out  1`: poll timeout; valid with `rsp_valid_o`.
- `wbm_cyc_o`, `wbm_stb_o`, `wbm_we_o  out  1`: Wishbone master controls.
- `wbm_adr_o  out  3`: Wishbone address.
- `wbm_dat_o  out  8`: Wishbone write data.
- `wbm_dat_i  in  8`: Wishbone read data.
- `wbm_ack_i  in  1`: Wishbone acknowledge.

## Operation
- **Reset value of every output:** 0, except `wbm_adr_o` = 0 and `wbm_dat_o` = 0.
- **Reset mid-transaction:** all state clears immediately and init reruns.
- **Init after reset:** write PRER lo (adr 0) = `PRESCALE[7:0]`, PRER hi (adr 1) = `PRESCALE[15:8]`, CTR (adr 2) = 0x80, then enter IDLE.
- **Accept:** a request is accepted on a cycle with `req_valid_i && req_ready_o`. The fields are latched and `req_ready_o` drops the next cycle.
- **Command byte bits:** STA = 0x80, STO = 0x40, RD = 0x20, WR = 0x10, ACK = 0x08, IACK = 0x01. Every CR write sets IACK.
- **Step primitive W(t, c):** TXR (adr 3) = t, CR (adr 4) = c, wait 2 idle cycles, then poll SR (adr 4) until SR[1] (TIP) = 0.
- **Write sequence:**
  - W({dev,0}, 0x91)
  - W(reg, 0x11)
  - W(wdata, 0x51)
- **Read sequence:**
  - W({dev,0}, 0x91)
  - W(reg, 0x11)
  - W({dev,1}, 0x91)
  - CR = 0x69 (STO, RD, NACK the single byte), wait 2 cycles, poll TIP = 0
  - read RXR (adr 3) into `rsp_rdata_o`
- **NACK check:** after each address/register step, SR[7] = 1 means NACK. On NACK: CR = 0x41, then go to STOPWAIT. A NACK on the final data byte of a write is reported but needs no extra STOP.
- **STOPWAIT:** poll until SR[6] (busy) = 0, then issue the response.
- **Timeout:** a poll count per wait phase exceeding `TIMEOUT` issues a response with `rsp_tmo_o` = 1 and writes CTR = 0x00, then 0x80 to force the core idle. `rsp_nack_o` = 0 in this case.
- **Response:** `rsp_valid_o` pulses one cycle in RESP, then the FSM returns to IDLE. `req_ready_o` rises the following cycle.
- **FSM states:** INIT, IDLE, LOAD_TX, WR_CR, GAP, POLL_TIP, RD_RX, ABORT_STO, STOPWAIT, RECOVER, RESP. A step counter (0..3) selects the byte and command for each step.

## Timing
- **Bus access:** assert `cyc`/`stb` (with `we`, `adr`, `dat`) and hold until `wbm_ack_i`. Capture `wbm_dat_i` on the ack cycle, deassert `cyc`/`stb` the next cycle, and keep them low for at least 1 cycle between accesses.
- **Access latency:** with the core's combinational ack, each access takes 2 cycles.
- **Post-CR gap:** the 2-cycle gap after a CR write guarantees TIP has been updated before the first poll. It is counted from the cycle after the CR ack.
- **Ack latency:** any `wbm_ack_i` latency is tolerated, and there is no Wishbone timeout.
- **Fixed latency:** latency from accept to `rsp_valid_o` equals the bus-dependent poll time plus a fixed overhead of 2 cycles per access.

## Structure
- **Package `i2c_seq_pkg`:**
  - register addresses: PRER_LO 0, PRER_HI 1, CTR 2, TXR/RXR 3, CR/SR 4
  - command bytes: 0x91, 0x11, 0x51, 0x69, 0x41
  - SR bit indices: 7, 6, 1
  - FSM state enum
- **Sub-module `i2c_wb_access`:** single-access Wishbone master with request (`adr`, `dat`, `we`) in and done/rdata out. It owns the cyc/stb/ack handshake and the idle cycle.

## Test plan
- **Init:** reset with `PRESCALE` = 0x0063. The bus shows writes adr0 = 0x63, adr1 = 0x00, adr2 = 0x80, and `req_ready_o` goes high.
- **Write:** device 0x50, reg 0x12, data 0xA5 against an ACKing slave model behind `i2c_master_top`. The slave sees bytes 0xA0, 0x12, 0xA5 then STOP, and the response is nack = 0, tmo = 0.
- **Read:** device 0x50, reg 0x12, slave returns 0x3C. The bus shows 0xA0, 0x12, repeated-START 0xA1, master NACK, STOP. The response is rdata = 0x3C.
- **Absent device:** device 0x23. The first address byte is NACKed, CR = 0x41 is issued, and the response has nack = 1 after busy clears. No further TXR writes occur.
- **Timeout:** SCL held low by the bench with `TIMEOUT` = 16. The response has tmo = 1 after 17 polls, and CTR is written 0x00 then 0x80.
- **Reset mid-read and ack latency:** deassert `arst_i` during POLL_TIP. Outputs are 0 in the same cycle, init reruns, and the next request completes normally. Repeat with `wbm_ack_i` delayed 3 cycles; the results are identical.
